// File: rtl/xc_aessub_dec_seq_if.sv
// rtl/xc_aessub_dec_seq_if.sv - request/response bundle for the sequential aessub decrypt unit
interface xc_aessub_dec_seq_if;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rot;
    logic        flush;
    logic        ready;
    logic [31:0] result;

    modport master (output valid, rs1, rs2, rot, flush, input ready, result);
    modport slave  (input valid, rs1, rs2, rot, flush, output ready, result);
endinterface

// File: rtl/xc_aessub_dec_seq.sv
// rtl/xc_aessub_dec_seq.sv - multi-cycle xc.aessub.dec/decrot using shared inverse S-box lanes
module xc_aessub_dec_seq #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input logic                 g_clk,
    input logic                 g_resetn,
    xc_aessub_dec_seq_if.slave  bus
);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // idx wraps modulo 4, so a step of 4 is a step of 0 and the single group starts at 0
    localparam logic [1:0] IDX_STEP = 2'(BYTES_PER_CYCLE);
    localparam logic [1:0] IDX_LAST = 2'(4 - BYTES_PER_CYCLE);

    // FIPS-197 inverse S-box, entry 0 first
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    logic [1:0]  fsm;
    logic [1:0]  idx;
    logic [31:0] opnd;
    logic [31:0] acc;
    logic        rot_q;

    logic [1:0]  lane   [BYTES_PER_CYCLE];
    logic [7:0]  sb_out [BYTES_PER_CYCLE];
    logic [31:0] gathered;
    logic        unused_bits;

    assign gathered    = {bus.rs2[31:24], bus.rs1[23:16], bus.rs2[15:8], bus.rs1[7:0]};
    // operand bytes that the gather does not select
    assign unused_bits = ^{bus.rs1[31:24], bus.rs1[15:8], bus.rs2[23:16], bus.rs2[7:0]};

    // shared S-box lanes: lane j handles byte idx+j of the latched operand
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            lane[j]   = idx + 2'(j);
            sb_out[j] = inv_sbox(opnd[{lane[j], 3'b000} +: 8]);
        end
    end

    // control FSM and datapath: latch in IDLE, one byte group per BUSY cycle, single DONE cycle
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm   <= S_IDLE;
            idx   <= 2'd0;
            opnd  <= 32'h0;
            rot_q <= 1'b0;
            acc   <= 32'h0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.valid && !bus.flush) begin
                        opnd  <= gathered;
                        rot_q <= bus.rot;
                        idx   <= 2'd0;
                        fsm   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.flush || !bus.valid) begin
                        fsm <= S_IDLE;
                    end else begin
                        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                            acc[{lane[j], 3'b000} +: 8] <= sb_out[j];
                        end
                        idx <= idx + IDX_STEP;
                        if (idx == IDX_LAST) begin
                            fsm <= S_DONE;
                        end
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

    // outputs decode registered state only, so nothing combinational reaches them from inputs
    assign bus.ready  = (fsm == S_DONE);
    assign bus.result = bus.ready ? (rot_q ? {acc[7:0], acc[31:8]} : acc) : 32'h0;

endmodule

// File: tb/tb_xc_aessub_dec_seq.sv
// tb/tb_xc_aessub_dec_seq.sv - scoreboard bench for xc_aessub_dec_seq at 1, 2 and 4 bytes per cycle
module tb_xc_aessub_dec_seq;

    typedef struct {
        int          inst;
        logic [31:0] res;
        int          due;
    } exp_t;

    logic        g_clk;
    logic        g_resetn;
    logic [2:0]  vld;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rot;
    logic        flush;
    logic [2:0]  rdy;
    logic [31:0] res [3];

    int          cyc;
    int          n_checks;
    int          n_errors;
    exp_t        sbq [$];
    exp_t        cur;
    logic [2:0]  hit;
    logic [7:0]  inv_tab [256];

    localparam logic [31:0] OP_A = 32'h00770063;
    localparam logic [31:0] OP_B = 32'h7B007C00;
    localparam logic [31:0] OP_C = 32'h16ED0016;

    xc_aessub_dec_seq_if if0 ();
    xc_aessub_dec_seq_if if1 ();
    xc_aessub_dec_seq_if if2 ();

    assign if0.valid = vld[0];
    assign if0.rs1   = rs1;
    assign if0.rs2   = rs2;
    assign if0.rot   = rot;
    assign if0.flush = flush;
    assign if1.valid = vld[1];
    assign if1.rs1   = rs1;
    assign if1.rs2   = rs2;
    assign if1.rot   = rot;
    assign if1.flush = flush;
    assign if2.valid = vld[2];
    assign if2.rs1   = rs1;
    assign if2.rs2   = rs2;
    assign if2.rot   = rot;
    assign if2.flush = flush;
    assign rdy    = {if2.ready, if1.ready, if0.ready};
    assign res[0] = if0.result;
    assign res[1] = if1.result;
    assign res[2] = if2.result;

    xc_aessub_dec_seq #(.BYTES_PER_CYCLE(1)) dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(if0));
    xc_aessub_dec_seq #(.BYTES_PER_CYCLE(2)) dut2 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(if1));
    xc_aessub_dec_seq #(.BYTES_PER_CYCLE(4)) dut4 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(if2));

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // forward S-box from GF(2^8) inverse and the affine map, inverted into inv_tab
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) y = 8'(c);
        end
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] t;
        t = {inv_tab[b[31:24]], inv_tab[a[23:16]], inv_tab[b[15:8]], inv_tab[a[7:0]]};
        return r ? {t[7:0], t[31:8]} : t;
    endfunction

    function automatic int bpc(input int sel);
        case (sel)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    // mode: 0 normal, 1 valid drop in BUSY, 2 flush in BUSY, 3 flush in DONE, 4 flush in IDLE, 5 re-issue
    task automatic run_req(input int sel, input int mode, input logic [31:0] a, input logic [31:0] b,
                           input logic r, input int k, input logic [31:0] e);
        int lat;
        int c0;
        lat = 4 / bpc(sel);
        rs1 = a;
        rs2 = b;
        rot = r;
        flush = (mode == 4);
        vld[sel] = 1'b1;
        c0 = cyc;
        if (mode == 0 || mode == 3 || mode == 5) sbq.push_back('{sel, e, c0 + 1 + lat});
        if (mode == 5) sbq.push_back('{sel, e, c0 + 2 * lat + 3});
        case (mode)
            0: begin
                for (int i = 1; i <= lat + 1; i++) begin
                    @(negedge g_clk);
                    if (i <= lat) begin
                        rs1 = $urandom;
                        rs2 = $urandom;
                        rot = 1'($urandom);
                    end
                end
                vld[sel] = 1'b0;
                @(negedge g_clk);
            end
            1: begin
                repeat (k + 1) @(negedge g_clk);
                vld[sel] = 1'b0;
                @(negedge g_clk);
            end
            2: begin
                repeat (k + 1) @(negedge g_clk);
                flush = 1'b1;
                @(negedge g_clk);
                flush = 1'b0;
                vld[sel] = 1'b0;
            end
            3: begin
                repeat (lat + 1) @(negedge g_clk);
                flush = 1'b1;
                @(negedge g_clk);
                flush = 1'b0;
                vld[sel] = 1'b0;
            end
            4: begin
                @(negedge g_clk);
                flush = 1'b0;
                vld[sel] = 1'b0;
            end
            default: begin
                repeat (2 * lat + 3) @(negedge g_clk);
                vld[sel] = 1'b0;
                @(negedge g_clk);
            end
        endcase
    endtask

    // scoreboard monitor: due pulses must appear on time with the right word, nothing else may pulse
    always @(negedge g_clk) begin
        hit = 3'b000;
        if (sbq.size() != 0 && cyc >= sbq[0].due) begin
            cur = sbq.pop_front();
            check("ready_on_time", {31'b0, rdy[cur.inst]}, 32'd1);
            if (rdy[cur.inst]) begin
                hit[cur.inst] = 1'b1;
                check("result", res[cur.inst], cur.res);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (rdy[i] && !hit[i]) check("extra_ready", {31'b0, rdy[i]}, 32'd0);
            if (!rdy[i]) check("result_zero", res[i], 32'd0);
        end
    end

    initial begin
        int sel;
        int m;
        int mode;
        logic [31:0] a;
        logic [31:0] b;
        logic r;
        g_resetn = 1'b0;
        vld = 3'b000;
        rs1 = 32'h0;
        rs2 = 32'h0;
        rot = 1'b0;
        flush = 1'b0;
        cyc = 0;
        n_checks = 0;
        n_errors = 0;
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        repeat (2) @(negedge g_clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", {31'b0, rdy[i]}, 32'd0);
            check("reset_result", res[i], 32'd0);
        end
        g_resetn = 1'b1;
        @(negedge g_clk);

        run_req(0, 0, OP_A, OP_B, 1'b0, 0, 32'h03020100);
        run_req(0, 0, OP_A, OP_B, 1'b1, 0, 32'h00030201);
        run_req(0, 0, OP_C, OP_C, 1'b0, 0, 32'hFF5352FF);
        run_req(1, 0, OP_C, OP_C, 1'b0, 0, 32'hFF5352FF);
        run_req(2, 0, OP_C, OP_C, 1'b0, 0, 32'hFF5352FF);
        run_req(0, 1, OP_C, OP_C, 1'b0, 1, 32'h0);
        run_req(0, 0, OP_A, OP_B, 1'b0, 0, 32'h03020100);
        run_req(0, 2, OP_C, OP_C, 1'b0, 1, 32'h0);
        run_req(0, 0, OP_A, OP_B, 1'b0, 0, 32'h03020100);
        run_req(0, 3, OP_A, OP_B, 1'b1, 0, 32'h00030201);
        run_req(0, 4, OP_A, OP_B, 1'b0, 0, 32'h0);
        run_req(0, 5, OP_A, OP_B, 1'b0, 0, 32'h03020100);
        run_req(1, 5, OP_C, OP_C, 1'b1, 0, 32'hFFFF5352);
        run_req(2, 5, OP_C, OP_C, 1'b1, 0, 32'hFFFF5352);

        // reset pulled between edges while BUSY
        rs1 = OP_C;
        rs2 = OP_C;
        rot = 1'b0;
        vld[0] = 1'b1;
        repeat (2) @(negedge g_clk);
        #3 g_resetn = 1'b0;
        #1;
        check("rst_busy_ready", {31'b0, rdy[0]}, 32'd0);
        check("rst_busy_result", res[0], 32'd0);
        @(negedge g_clk);
        vld[0] = 1'b0;
        g_resetn = 1'b1;
        @(negedge g_clk);
        run_req(0, 0, OP_A, OP_B, 1'b0, 0, 32'h03020100);

        // reset pulled between edges while DONE drops ready at once
        rs1 = OP_C;
        rs2 = OP_C;
        rot = 1'b1;
        vld[0] = 1'b1;
        repeat (4) @(negedge g_clk);
        @(posedge g_clk);
        #2;
        check("done_ready", {31'b0, rdy[0]}, 32'd1);
        check("done_result", res[0], 32'hFFFF5352);
        g_resetn = 1'b0;
        #1;
        check("rst_done_ready", {31'b0, rdy[0]}, 32'd0);
        check("rst_done_result", res[0], 32'd0);
        @(negedge g_clk);
        vld[0] = 1'b0;
        g_resetn = 1'b1;
        @(negedge g_clk);
        run_req(0, 0, OP_A, OP_B, 1'b1, 0, 32'h00030201);

        for (int n = 0; n < 10000; n++) begin
            sel = $urandom_range(0, 2);
            m = $urandom_range(0, 9);
            mode = (m < 5) ? 0 : m - 4;
            a = $urandom;
            b = $urandom;
            r = 1'($urandom);
            run_req(sel, mode, a, b, r, $urandom_range(0, 4 / bpc(sel) - 1), model(a, b, r));
        end

        repeat (4) @(negedge g_clk);
        check("sb_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
